tap_dr_access: RTL and testbench

- Parametrised JTAG data register that turns scanned commands into bus transactions.
- Supports write, read and read-next (address auto-increment), with a valid/ready-style bus handshake.
- Read data and status are captured back into the scan chain.
- Sits between the TAP controller (capture/shift/update strobes) and the debug memory bus master port.

---
 rtl/tap_pkg.sv | 38 +++
 rtl/tap_dr_shifter.sv | 43 ++++
 rtl/tap_dr_access.sv | 184 ++++++++++++++++++
 tb/tb_tap_dr_access.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tap_pkg.sv
// Shared types and field layout helpers for the TAP data registers.
package tap_pkg;

    localparam int unsigned globalAddress_width = 64;
    localparam int unsigned data_width          = 32;

    // Command codes carried in the top two bits of the access DR.
    typedef enum logic [1:0] {
        OpNop      = 2'b00,
        OpWrite    = 2'b01,
        OpRead     = 2'b10,
        OpReadNext = 2'b11
    } tap_dr_op_e;

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StReq   = 2'b01,
        StRdata = 2'b10
    } tap_acc_state_e;

    // Access DR layout, LSB first out: data, then address, then op/status.
    function automatic int unsigned dr_data_lsb();
        return 0;
    endfunction

    function automatic int unsigned dr_addr_lsb(input int unsigned dw);
        return dw;
    endfunction

    function automatic int unsigned dr_op_lsb(input int unsigned aw, input int unsigned dw);
        return aw + dw;
    endfunction

    function automatic int unsigned dr_width(input int unsigned aw, input int unsigned dw);
        return 2 + aw + dw;
    endfunction

endpackage

// File: rtl/tap_dr_shifter.sv
// Generic capture/shift data register with parallel load and parallel out.
module tap_dr_shifter #(
    parameter int unsigned Width = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             capture_i,
    input  logic             shift_i,
    input  logic             tdi_i,
    input  logic [Width-1:0] cap_data_i,
    output logic [Width-1:0] sr_o,
    output logic             tdo_o
);

    logic [Width-1:0] sr_q;
    logic [Width-1:0] sr_d;

    // Capture wins over shift when both strobes are raised together.
    always_comb begin
        sr_d = sr_q;
        if (en_i) begin
            if (capture_i) begin
                sr_d = cap_data_i;
            end else if (shift_i) begin
                sr_d = {tdi_i, sr_q[Width-1:1]};
            end
        end
    end

    // Shift register state with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign sr_o  = sr_q;
    assign tdo_o = sr_q[0];

endmodule

// File: rtl/tap_dr_access.sv
// JTAG data register that turns scanned commands into debug bus transactions.
module tap_dr_access
    import tap_pkg::*;
#(
    parameter int unsigned AW        = tap_pkg::globalAddress_width,
    parameter int unsigned DW        = tap_pkg::data_width,
    parameter int unsigned ADDR_STEP = 4
) (
    input  logic          tck_i,
    input  logic          trst_i,
    input  logic          tdi_i,
    input  logic          captureDR_i,
    input  logic          shiftDR_i,
    input  logic          updateDR_i,
    input  logic          drEna_i,
    output logic          tdo_o,
    output logic          req_o,
    output logic          we_o,
    output logic [AW-1:0] addr_o,
    output logic [DW-1:0] wdata_o,
    input  logic          gnt_i,
    input  logic          rvalid_i,
    input  logic [DW-1:0] rdata_i,
    output logic          busy_o,
    output logic          err_o
);

    localparam int unsigned DRW     = dr_width(AW, DW);
    localparam int unsigned DataLsb = dr_data_lsb();
    localparam int unsigned AddrLsb = dr_addr_lsb(DW);
    localparam int unsigned OpLsb   = dr_op_lsb(AW, DW);

    tap_acc_state_e state_q, state_d;

    logic [AW-1:0]  addr_q, addr_d;
    logic [DW-1:0]  wdata_q, wdata_d;
    logic [DW-1:0]  rdata_q, rdata_d;
    logic           we_q, we_d;
    logic           err_q, err_d;

    logic [DRW-1:0] sr;
    logic [DRW-1:0] cap_data;
    logic [AW-1:0]  sr_addr;
    logic [DW-1:0]  sr_data;
    tap_dr_op_e     op;
    logic           upd_cmd;
    logic           rd_done;

    // Status pair sits in the op slot so a scan-out reports err/busy alongside the result.
    assign cap_data = {err_q, busy_o, addr_q, rdata_q};

    tap_dr_shifter #(
        .Width (DRW)
    ) u_shifter (
        .clk_i      (tck_i),
        .rst_i      (trst_i),
        .en_i       (drEna_i),
        .capture_i  (captureDR_i),
        .shift_i    (shiftDR_i),
        .tdi_i      (tdi_i),
        .cap_data_i (cap_data),
        .sr_o       (sr),
        .tdo_o      (tdo_o)
    );

    assign sr_data = sr[DataLsb +: DW];
    assign sr_addr = sr[AddrLsb +: AW];
    assign op      = tap_dr_op_e'(sr[OpLsb +: 2]);

    // Update only counts when no higher-priority strobe is active.
    assign upd_cmd = drEna_i & updateDR_i & ~captureDR_i & ~shiftDR_i;

    // FSM state register.
    always_ff @(posedge tck_i) begin
        if (trst_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; also flags the cycle in which read data is taken.
    always_comb begin
        state_d = state_q;
        rd_done = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (upd_cmd && (op != OpNop)) begin
                    state_d = StReq;
                end
            end
            StReq: begin
                if (gnt_i) begin
                    if (we_q) begin
                        state_d = StIdle;
                    end else if (rvalid_i) begin
                        rd_done = 1'b1;
                        state_d = StIdle;
                    end else begin
                        state_d = StRdata;
                    end
                end
            end
            StRdata: begin
                if (rvalid_i) begin
                    rd_done = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs decoded from the registered state.
    always_comb begin
        req_o  = (state_q == StReq);
        busy_o = (state_q != StIdle);
    end

    // Next values for the bus-side registers and the sticky error.
    always_comb begin
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        if (upd_cmd) begin
            if (state_q == StIdle) begin
                case (op)
                    OpWrite: begin
                        addr_d  = sr_addr;
                        wdata_d = sr_data;
                        we_d    = 1'b1;
                    end
                    OpRead: begin
                        addr_d = sr_addr;
                        we_d   = 1'b0;
                    end
                    OpReadNext: begin
                        // Shifted address is ignored; wraps modulo 2^AW.
                        addr_d = addr_q + AW'(ADDR_STEP);
                        we_d   = 1'b0;
                    end
                    default: begin
                        if (sr_data[0]) begin
                            err_d = 1'b0;
                        end
                    end
                endcase
            end else if (op != OpNop) begin
                // Command arrived while busy: drop it and flag the overrun.
                err_d = 1'b1;
            end else if (sr_data[0]) begin
                err_d = 1'b0;
            end
        end
        if (rd_done) begin
            rdata_d = rdata_i;
        end
    end

    // Bus-side registers with synchronous reset.
    always_ff @(posedge tck_i) begin
        if (trst_i) begin
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign addr_o  = addr_q;
    assign wdata_o = wdata_q;
    assign we_o    = we_q;
    assign err_o   = err_q;

endmodule

// File: tb/tb_tap_dr_access.sv
// Scoreboard bench for tap_dr_access: bus transactions and scan-out words.
module tb_tap_dr_access;

    localparam int unsigned AW  = 64;
    localparam int unsigned DW  = 32;
    localparam int unsigned DRW = 2 + AW + DW;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } txn_t;

    logic          tck = 1'b0;
    logic          trst = 1'b1;
    logic          tdi = 1'b0;
    logic          capture = 1'b0;
    logic          shift = 1'b0;
    logic          update = 1'b0;
    logic          dr_ena = 1'b0;
    logic          tdo;
    logic          req;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          gnt = 1'b0;
    logic          rvalid = 1'b0;
    logic [DW-1:0] rdata = '0;
    logic          busy;
    logic          err;

    int n_checks = 0;
    int n_errors = 0;

    txn_t           exp_q[$];
    logic [DRW-1:0] scan_q[$];

    tap_dr_access #(
        .AW        (AW),
        .DW        (DW),
        .ADDR_STEP (4)
    ) dut (
        .tck_i       (tck),
        .trst_i      (trst),
        .tdi_i       (tdi),
        .captureDR_i (capture),
        .shiftDR_i   (shift),
        .updateDR_i  (update),
        .drEna_i     (dr_ena),
        .tdo_o       (tdo),
        .req_o       (req),
        .we_o        (we),
        .addr_o      (addr),
        .wdata_o     (wdata),
        .gnt_i       (gnt),
        .rvalid_i    (rvalid),
        .rdata_i     (rdata),
        .busy_o      (busy),
        .err_o       (err)
    );

    always #5 tck = ~tck;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Inputs change #1 after the rising edge; outputs are then stable.
    task automatic tick();
        @(posedge tck);
        #1;
    endtask

    task automatic expect_txn(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        txn_t t;
        t.we    = w;
        t.addr  = a;
        t.wdata = d;
        exp_q.push_back(t);
    endtask

    // Scan a command in and apply Update-DR; returns in the cycle after update.
    task automatic issue(input logic [1:0] op, input logic [AW-1:0] a, input logic [DW-1:0] d);
        logic [DRW-1:0] v;
        v      = {op, a, d};
        dr_ena = 1'b1;
        for (int i = 0; i < DRW; i++) begin
            shift = 1'b1;
            tdi   = v[i];
            tick();
        end
        shift  = 1'b0;
        update = 1'b1;
        tick();
        update = 1'b0;
    endtask

    // Capture-DR then shift the whole register out through tdo.
    task automatic scan_capture(input string tag, input logic [DRW-1:0] exp);
        logic [DRW-1:0] got;
        logic [DRW-1:0] want;
        scan_q.push_back(exp);
        dr_ena  = 1'b1;
        capture = 1'b1;
        tick();
        capture = 1'b0;
        shift   = 1'b1;
        tdi     = 1'b0;
        for (int i = 0; i < DRW; i++) begin
            got[i] = tdo;
            tick();
        end
        shift = 1'b0;
        want  = scan_q.pop_front();
        check_eq({tag, "_status"}, got[DRW-1:DRW-2], want[DRW-1:DRW-2]);
        check_eq({tag, "_addr"}, got[DW +: AW], want[DW +: AW]);
        check_eq({tag, "_data"}, got[DW-1:0], want[DW-1:0]);
    endtask

    // Bus monitor: every accepted request is matched against the scoreboard.
    always @(negedge tck) begin
        txn_t t;
        if (!trst && req && gnt) begin
            if (exp_q.size() == 0) begin
                check_eq("unexpected_req", {AW'(0), addr}, {AW'(1), addr});
            end else begin
                t = exp_q.pop_front();
                check_eq("txn_we", we, t.we);
                check_eq("txn_addr", addr, t.addr);
                if (t.we) begin
                    check_eq("txn_wdata", wdata, t.wdata);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        trst = 1'b1;
        tick();
        tick();
        check_eq("rst_req", req, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_err", err, 0);
        check_eq("rst_tdo", tdo, 0);
        check_eq("rst_addr", addr, 0);
        trst = 1'b0;
        tick();

        // Write with grant held off for three request cycles
        expect_txn(1'b1, 64'h1000, 32'hDEADBEEF);
        issue(2'b01, 64'h1000, 32'hDEADBEEF);
        check_eq("wr_req1", req, 1);
        check_eq("wr_busy", busy, 1);
        check_eq("wr_we", we, 1);
        check_eq("wr_addr", addr, 64'h1000);
        check_eq("wr_wdata", wdata, 32'hDEADBEEF);
        tick();
        check_eq("wr_req2", req, 1);
        tick();
        check_eq("wr_req3", req, 1);
        gnt = 1'b1;
        tick();
        gnt = 1'b0;
        check_eq("wr_busy_drop", busy, 0);
        check_eq("wr_req_drop", req, 0);

        // Read with data two cycles after the grant
        expect_txn(1'b0, 64'h2000, '0);
        issue(2'b10, 64'h2000, 32'h0);
        check_eq("rd_req", req, 1);
        check_eq("rd_we", we, 0);
        gnt = 1'b1;
        tick();
        gnt = 1'b0;
        check_eq("rd_wait_busy", busy, 1);
        check_eq("rd_wait_req", req, 0);
        tick();
        rvalid = 1'b1;
        rdata  = 32'hCAFEF00D;
        tick();
        rvalid = 1'b0;
        check_eq("rd_done_busy", busy, 0);
        scan_capture("rd_cap", {2'b00, 64'h2000, 32'hCAFEF00D});

        // Two read-next commands; shifted address must be ignored
        expect_txn(1'b0, 64'h2004, '0);
        issue(2'b11, 64'hDEAD_0000, 32'h0);
        check_eq("rn1_addr", addr, 64'h2004);
        gnt    = 1'b1;
        rvalid = 1'b1;
        rdata  = 32'h11;
        tick();
        gnt    = 1'b0;
        rvalid = 1'b0;
        check_eq("rn1_busy", busy, 0);
        expect_txn(1'b0, 64'h2008, '0);
        issue(2'b11, 64'h0, 32'h0);
        check_eq("rn2_addr", addr, 64'h2008);
        gnt = 1'b1;
        tick();
        gnt = 1'b0;
        rvalid = 1'b1;
        rdata  = 32'h22;
        tick();
        rvalid = 1'b0;
        // Stray rvalid while idle must not overwrite the captured data
        rvalid = 1'b1;
        rdata  = 32'hBAD0BAD0;
        tick();
        rvalid = 1'b0;
        scan_capture("rn_cap", {2'b00, 64'h2008, 32'h22});

        // Command during RDATA is dropped and sets the sticky error
        expect_txn(1'b0, 64'h3000, '0);
        issue(2'b10, 64'h3000, 32'h0);
        gnt = 1'b1;
        tick();
        gnt = 1'b0;
        issue(2'b01, 64'h9999, 32'h5555);
        check_eq("ovr_err", err, 1);
        check_eq("ovr_busy", busy, 1);
        check_eq("ovr_addr", addr, 64'h3000);
        check_eq("ovr_we", we, 0);
        check_eq("ovr_req", req, 0);
        rvalid = 1'b1;
        rdata  = 32'h33;
        tick();
        rvalid = 1'b0;
        check_eq("ovr_idle", busy, 0);
        scan_capture("ovr_cap", {2'b10, 64'h3000, 32'h33});
        issue(2'b00, 64'h0, 32'h0);
        check_eq("nop0_err_kept", err, 1);
        check_eq("nop0_busy", busy, 0);
        issue(2'b00, 64'h0, 32'h1);
        check_eq("nop1_err_clr", err, 0);

        // Read-next address wrap
        expect_txn(1'b0, 64'hFFFF_FFFF_FFFF_FFFC, '0);
        issue(2'b10, 64'hFFFF_FFFF_FFFF_FFFC, 32'h0);
        gnt    = 1'b1;
        rvalid = 1'b1;
        rdata  = 32'h44;
        tick();
        gnt    = 1'b0;
        rvalid = 1'b0;
        expect_txn(1'b0, 64'h0, '0);
        issue(2'b11, 64'h0, 32'h0);
        check_eq("wrap_addr", addr, 64'h0);
        gnt    = 1'b1;
        rvalid = 1'b1;
        tick();
        gnt    = 1'b0;
        rvalid = 1'b0;

        // Reset aborts an in-flight write
        issue(2'b01, 64'h4000, 32'hABCD1234);
        check_eq("abort_req_before", req, 1);
        trst = 1'b1;
        tick();
        check_eq("abort_req", req, 0);
        check_eq("abort_busy", busy, 0);
        check_eq("abort_tdo", tdo, 0);
        check_eq("abort_addr", addr, 0);
        check_eq("abort_wdata", wdata, 0);
        check_eq("abort_we", we, 0);
        check_eq("abort_err", err, 0);
        trst = 1'b0;
        tick();
        scan_capture("abort_cap", '0);

        // Normal write after reset
        expect_txn(1'b1, 64'h5000, 32'h12345678);
        issue(2'b01, 64'h5000, 32'h12345678);
        check_eq("post_we", we, 1);
        gnt = 1'b1;
        tick();
        gnt = 1'b0;
        check_eq("post_busy", busy, 0);
        check_eq("post_wdata", wdata, 32'h12345678);
        tick();
        check_eq("queue_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
